// File: rtl/vga_grid_pixel.sv
// vga_grid_pixel: VGA raster timing generator plus board renderer.
// Walks an 800x525 raster (640x480 active), maps each pixel onto an
// 8x8-addressable board of 3-bit colour cells and emits the colour index
// together with hsync/vsync/video_on, all describing the same pixel.
// Optional build macro GRID_LINES_EN: draws colour 1 on the first pixel
// row and column of every board cell; undefined means cells are filled.
module vga_grid_pixel #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CELL_LOG2 = 6,
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 7,
  parameter int X_OFF     = 64,
  parameter int Y_OFF     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_color,
  output logic [2:0] color,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CELL    = 2 ** CELL_LOG2;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] X_LO     = 10'(X_OFF);
  localparam logic [9:0] X_HI     = 10'(X_OFF + GRID_COLS * CELL);
  localparam logic [9:0] Y_LO     = 10'(Y_OFF);
  localparam logic [9:0] Y_HI     = 10'(Y_OFF + GRID_ROWS * CELL);
  localparam logic [3:0] ROW_LIM  = 4'(GRID_ROWS);
  localparam logic [3:0] COL_LIM  = 4'(GRID_COLS);
`ifdef GRID_LINES_EN
  localparam logic [9:0] CELL_MASK = 10'(CELL - 1);
`endif

  // Raster state
  logic [DIV_W-1:0] div_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;

  // Next-state values
  logic             tick_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             frame_s;
  logic [DIV_W-1:0] div_next_s;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;

  // Pixel decode of the current counters
  logic       active_s;
  logic       hsync_s;
  logic       vsync_s;
  logic       in_board_s;
  logic [9:0] h_rel_s;
  logic [9:0] v_rel_s;
  logic [9:0] h_cell_s;
  logic [9:0] v_cell_s;
  logic [5:0] addr_s;
  logic       unused_cell_bits;

  // Stage 1 registers
  logic       s1_active_r;
  logic       s1_hsync_r;
  logic       s1_vsync_r;
  logic       s1_in_board_r;
  logic [5:0] s1_addr_r;
`ifdef GRID_LINES_EN
  logic       line_s;
  logic       s1_line_r;
`endif

  // Board storage: address is {row, col}
  logic [2:0] cells_r [0:63];
  logic       wr_ok_s;
  logic [2:0] pix_color_s;

  // Pixel tick and raster counter next-state logic
  always_comb begin
    tick_s   = (div_r == DIV_LAST);
    h_wrap_s = (h_cnt_r == H_LAST);
    v_wrap_s = (v_cnt_r == V_LAST);
    frame_s  = tick_s && h_wrap_s && v_wrap_s;
    if (tick_s) begin
      div_next_s = {DIV_W{1'b0}};
    end else begin
      div_next_s = div_r + 1'b1;
    end
    if (!tick_s) begin
      h_next_s = h_cnt_r;
    end else if (h_wrap_s) begin
      h_next_s = 10'd0;
    end else begin
      h_next_s = h_cnt_r + 10'd1;
    end
    if (!(tick_s && h_wrap_s)) begin
      v_next_s = v_cnt_r;
    end else if (v_wrap_s) begin
      v_next_s = 10'd0;
    end else begin
      v_next_s = v_cnt_r + 10'd1;
    end
  end

  // Raster counters, divider and the frame wrap pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r      <= {DIV_W{1'b0}};
      h_cnt_r    <= 10'd0;
      v_cnt_r    <= 10'd0;
      frame_tick <= 1'b0;
    end else begin
      div_r      <= div_next_s;
      h_cnt_r    <= h_next_s;
      v_cnt_r    <= v_next_s;
      frame_tick <= frame_s;
    end
  end

  // Decode active area, sync pulses and board cell for the current pixel;
  // the subtraction may wrap off-board, in_board masks that case
  always_comb begin
    active_s   = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    hsync_s    = !((h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST));
    vsync_s    = !((v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST));
    in_board_s = (h_cnt_r >= X_LO) && (h_cnt_r < X_HI) &&
                 (v_cnt_r >= Y_LO) && (v_cnt_r < Y_HI);
    h_rel_s    = h_cnt_r - X_LO;
    v_rel_s    = v_cnt_r - Y_LO;
    h_cell_s   = h_rel_s >> CELL_LOG2;
    v_cell_s   = v_rel_s >> CELL_LOG2;
    addr_s     = {v_cell_s[2:0], h_cell_s[2:0]};
`ifdef GRID_LINES_EN
    line_s     = ((h_rel_s & CELL_MASK) == 10'd0) || ((v_rel_s & CELL_MASK) == 10'd0);
`endif
  end

  assign unused_cell_bits = ^{h_cell_s[9:3], v_cell_s[9:3]};

  // Stage 1: capture decoded pixel attributes on each pixel tick
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_active_r   <= 1'b0;
      s1_hsync_r    <= 1'b1;
      s1_vsync_r    <= 1'b1;
      s1_in_board_r <= 1'b0;
      s1_addr_r     <= 6'd0;
`ifdef GRID_LINES_EN
      s1_line_r     <= 1'b0;
`endif
    end else if (tick_s) begin
      s1_active_r   <= active_s;
      s1_hsync_r    <= hsync_s;
      s1_vsync_r    <= vsync_s;
      s1_in_board_r <= in_board_s;
      s1_addr_r     <= addr_s;
`ifdef GRID_LINES_EN
      s1_line_r     <= line_s;
`endif
    end
  end

  // Writes outside the configured board are dropped
  always_comb begin
    wr_ok_s = ({1'b0, wr_row} < ROW_LIM) && ({1'b0, wr_col} < COL_LIM);
  end

  // Cell register file; writes are independent of the pixel tick
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        cells_r[i] <= 3'd0;
      end
    end else if (wr_en && wr_ok_s) begin
      cells_r[{wr_row, wr_col}] <= wr_color;
    end
  end

  // Stage 2 colour select: background outside the board or when blanked
  always_comb begin
    if (s1_active_r && s1_in_board_r) begin
`ifdef GRID_LINES_EN
      if (s1_line_r) begin
        pix_color_s = 3'd1;
      end else begin
        pix_color_s = cells_r[s1_addr_r];
      end
`else
      pix_color_s = cells_r[s1_addr_r];
`endif
    end else begin
      pix_color_s = 3'd0;
    end
  end

  // Stage 2: registered outputs, all aligned to the same pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      color    <= 3'd0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (tick_s) begin
      color    <= pix_color_s;
      hsync    <= s1_hsync_r;
      vsync    <= s1_vsync_r;
      video_on <= s1_active_r;
    end
  end

endmodule

// File: tb/tb_vga_grid_pixel.sv
// Testbench for vga_grid_pixel. Two instances share clock, reset and write
// port: u0 uses a scaled-down raster (80x48 total, 4-pixel cells) so a whole
// frame fits in the run, u1 uses the full 640x480 defaults for the early lines.
// Expected responses are queued with the clk count at which they must appear;
// a monitor pops and compares them on the falling edge.
module tb_vga_grid_pixel;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [2:0] wr_color;
  logic [2:0] c0, c1;
  logic       hs0, hs1, vs0, vs1, vo0, vo1, ft0, ft1;

  int cyc;
  int checks;
  int errors;

  localparam int R0 = 3;      // last clk count with rst high at start
  localparam int R2 = 27403;  // last clk count of the mid-run reset

`ifdef GRID_LINES_EN
  localparam logic [2:0] CORNER = 3'd1;
`else
  localparam logic [2:0] CORNER = 3'd5;
`endif

  typedef struct {
    int         cyc;
    int         dut;
    int         id;
    logic [2:0] color;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       ft;
  } exp_t;

  exp_t q[$];

  vga_grid_pixel #(
    .CLK_DIV(2), .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CELL_LOG2(2), .GRID_COLS(8), .GRID_ROWS(7), .X_OFF(4), .Y_OFF(2)
  ) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_color(wr_color), .color(c0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .frame_tick(ft0)
  );

  vga_grid_pixel u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_color(wr_color), .color(c1), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .frame_tick(ft1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running clk counter used to time every expectation
  always @(posedge clk) cyc <= cyc + 1;

  // Output of pixel (x,y) is valid two ticks after the counter reaches it
  function automatic int px0(input int x, input int y, input int f, input int base);
    return base + 2 * (f * 3840 + y * 80 + x) + 4;
  endfunction

  function automatic int px1(input int x, input int y, input int base);
    return base + 2 * (y * 800 + x) + 4;
  endfunction

  task automatic push_exp(input int c, input int d, input int id, input logic [2:0] col,
                          input logic vid, input logic hs, input logic vs, input logic ft);
    exp_t e;
    int   idx;
    e.cyc = c; e.dut = d; e.id = id; e.color = col;
    e.vid = vid; e.hs = hs; e.vs = vs; e.ft = ft;
    idx = q.size();
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc > c) idx = i;
    end
    q.insert(idx, e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] r, input logic [2:0] c, input logic [2:0] v);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_color = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Monitor: compare every queued expectation when its clk count arrives
  initial begin : monitor
    exp_t       e;
    logic [6:0] got;
    logic [6:0] want;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL chk%0d missed: sampled at cyc %0d, required at cyc %0d", e.id, cyc, e.cyc);
        end else begin
          got  = (e.dut == 0) ? {c0, vo0, hs0, vs0, ft0} : {c1, vo1, hs1, vs1, ft1};
          want = {e.color, e.vid, e.hs, e.vs, e.ft};
          if (got !== want) begin
            errors++;
            $display("FAIL chk%0d dut%0d cyc=%0d {color,video_on,hsync,vsync,frame_tick} got %b_%b%b%b%b required %b_%b%b%b%b",
                     e.id, e.dut, cyc, got[6:4], got[3], got[2], got[1], got[0],
                     want[6:4], want[3], want[2], want[1], want[0]);
          end
        end
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; wr_en = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_color = 3'd0;

    // Reset state on both instances
    push_exp(R0, 0, 1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(R0, 1, 2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Scaled instance, frame 0
    push_exp(px0(1, 1, 0, R0),   0, 10, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0); // active, off board
    push_exp(px0(4, 2, 0, R0),   0, 11, CORNER, 1'b1, 1'b1, 1'b1, 1'b0); // board corner
    push_exp(px0(5, 3, 0, R0),   0, 12, 3'd5,   1'b1, 1'b1, 1'b1, 1'b0); // inside cell (0,0)
    push_exp(px0(3, 5, 0, R0),   0, 13, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0); // left of board
    push_exp(px0(13, 11, 0, R0), 0, 14, 3'd3,   1'b1, 1'b1, 1'b1, 1'b0); // write same edge: old
    push_exp(px0(14, 11, 0, R0), 0, 15, 3'd4,   1'b1, 1'b1, 1'b1, 1'b0); // next pixel: new
    push_exp(px0(17, 27, 0, R0), 0, 16, 3'd2,   1'b1, 1'b1, 1'b1, 1'b0); // row 7 write ignored
    push_exp(px0(35, 29, 0, R0), 0, 17, 3'd7,   1'b1, 1'b1, 1'b1, 1'b0); // last board pixel
    push_exp(px0(36, 29, 0, R0), 0, 18, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0); // right of board
    push_exp(px0(35, 30, 0, R0), 0, 19, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0); // below board
    push_exp(px0(63, 30, 0, R0), 0, 20, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0); // last active column
    push_exp(px0(64, 30, 0, R0), 0, 21, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0); // first blank column
    push_exp(px0(67, 10, 0, R0), 0, 22, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px0(68, 10, 0, R0), 0, 23, 3'd0,   1'b0, 1'b0, 1'b1, 1'b0); // hsync start
    push_exp(px0(75, 10, 0, R0), 0, 24, 3'd0,   1'b0, 1'b0, 1'b1, 1'b0); // hsync end
    push_exp(px0(76, 10, 0, R0), 0, 25, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px0(10, 39, 0, R0), 0, 26, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0); // last active line
    push_exp(px0(10, 40, 0, R0), 0, 27, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px0(10, 41, 0, R0), 0, 28, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px0(10, 42, 0, R0), 0, 29, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0); // vsync start
    push_exp(px0(10, 43, 0, R0), 0, 30, 3'd0,   1'b0, 1'b1, 1'b0, 1'b0); // vsync end
    push_exp(px0(10, 44, 0, R0), 0, 31, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    // Frame wrap pulse: exactly one clk
    push_exp(R0 + 7679, 0, 32, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(R0 + 7680, 0, 33, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    push_exp(R0 + 7681, 0, 34, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px0(5, 3, 1, R0),   0, 35, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0); // frame 1 repeats

    // Full-size instance, early lines
    push_exp(px1(639, 0, R0), 1, 40, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0);
    push_exp(px1(640, 0, R0), 1, 41, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px1(655, 0, R0), 1, 42, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px1(656, 0, R0), 1, 43, 3'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(px1(751, 0, R0), 1, 44, 3'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(px1(752, 0, R0), 1, 45, 3'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px1(10, 10, R0), 1, 46, 3'd0,   1'b1, 1'b1, 1'b1, 1'b0);
    push_exp(px1(700, 10, R0), 1, 47, 3'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(px1(64, 16, R0), 1, 48, CORNER, 1'b1, 1'b1, 1'b1, 1'b0);
    push_exp(px1(65, 17, R0), 1, 49, 3'd5,   1'b1, 1'b1, 1'b1, 1'b0);

    // Mid-frame reset, then cells cleared and raster restarted
    push_exp(27401, 0, 50, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(R2, 0, 51, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(R2, 1, 52, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(px0(5, 3, 0, R2), 0, 53, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    push_exp(px0(9, 7, 0, R2), 0, 54, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0);

    wait_cyc(R0);
    rst = 1'b0;
    do_write(3'd0, 3'd0, 3'd5);
    do_write(3'd2, 3'd2, 3'd3);
    do_write(3'd6, 3'd3, 3'd2);
    do_write(3'd7, 3'd3, 3'd6);
    do_write(3'd6, 3'd7, 3'd7);
    wait_cyc(px0(13, 11, 0, R0) - 1);
    do_write(3'd2, 3'd2, 3'd4);

    wait_cyc(27400);
    rst = 1'b1;
    wait_cyc(27402);
    do_write(3'd0, 3'd0, 3'd6);  // lands on the last reset edge
    rst = 1'b0;
    do_write(3'd1, 3'd1, 3'd6);

    wait_cyc(px0(9, 7, 0, R2) + 4);
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL chk%0d never sampled: required at cyc %0d", q[0].id, q[0].cyc);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
